match_controller: RTL and testbench
===================================

# match_controller

Game-flow sequencer for the pong datapath. It starts a match, clears the scoreboard, times each serve, converts ball-exit events into single-cycle score pulses for the scoreboard, and checks the returned scores for a winner. It sits between the ball/physics logic and the scoreboard, and drives the ball enable and serve strobes.

## Interface
- `WIN_SCORE`, default 7: points needed to win; must be ≥ 1 and < 2^`SCORE_W`.
- `SERVE_DELAY`, default 60: cycles from the start of `SERVE_WAIT` until `serve` asserts; must be ≥ 1.
- `SCORE_W`, default 8: width of the score inputs.

- `clk`  in  1  master clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; begins a match from `IDLE` or `OVER`.
- `ball_out_left`  in  1  ball passed paddle 1's edge; paddle 2 scores.
- `ball_out_right`  in  1  ball passed paddle 2's edge; paddle 1 scores.
- `p1_score`  in  `SCORE_W`  current paddle 1 score from the scoreboard.
- `p2_score`  in  `SCORE_W`  current paddle 2 score from the scoreboard.
- `sb_clear`  out  1  scoreboard clear, one-cycle pulse.
- `p1_scored`  out  1  one-cycle pulse that increments paddle 1's score.
- `p2_scored`  out  1  one-cycle pulse that increments paddle 2's score.
- `serve`  out  1  one-cycle pulse that launches the ball.
- `serve_dir`  out  1  serve direction: 0 = toward paddle 1, 1 = toward paddle 2.
- `ball_en`  out  1  ball motion enable.
- `game_over`  out  1  high while in `OVER`.
- `winner`  out  1  0 = paddle 1, 1 = paddle 2; valid while `game_over` is high.

## Operation
- **Registered outputs:** all outputs are registered.
- **Reset:** state goes to `IDLE` and every output goes to 0, including `serve_dir` and `winner`. Asserting reset mid-match aborts the match immediately; no `sb_clear` is issued until the next `start`.
- **`IDLE`:** when `start` = 1, go to `CLEAR`.
- **`CLEAR`:** `sb_clear` = 1 for exactly this one cycle. Load the serve timer with `SERVE_DELAY-1`. Set `serve_dir` = 0. Go to `SERVE_WAIT`.
- **`SERVE_WAIT`:**
  - Decrement the timer each cycle.
  - On the cycle the timer reads 0: `serve` = 1, `ball_en` = 1, go to `PLAY`.
  - Ball-exit inputs are ignored.
- **`PLAY`:** `ball_en` = 1.
  - `ball_out_right` = 1: assert `p1_scored`, set `serve_dir` = 1, go to `SCORED`.
  - Otherwise `ball_out_left` = 1: assert `p2_scored`, set `serve_dir` = 0, go to `SCORED`.
  - Both inputs high in the same cycle: paddle 1 wins the point. Exactly one scored pulse is issued.
  - `start` is ignored.
- **`SCORED`:** `ball_en` = 0. Wait one cycle so the scoreboard registers the increment, then go to `CHECK`.
- **`CHECK`:** compare the scores, unsigned.
  - `p1_score` ≥ `WIN_SCORE`: `winner` = 0, go to `OVER`.
  - Else `p2_score` ≥ `WIN_SCORE`: `winner` = 1, go to `OVER`.
  - Else reload the timer and go to `SERVE_WAIT`.
  - Under `WIN_BY_TWO_EN`, a win additionally requires a lead of 2 or more.
- **`OVER`:** `game_over` = 1 and `ball_en` = 0.
  - When `start` = 1: `game_over` = 0, go to `CLEAR`.
  - Holding `start` high for several cycles starts exactly one match. `start` is re-sampled only in `IDLE` and `OVER`.

## Timing
- **Start to clear:** `start` sampled at edge N in `IDLE` → `sb_clear` high during cycle N+1.
- **Clear to serve:** `serve` and `ball_en` rise exactly `SERVE_DELAY` cycles after the `sb_clear` cycle. With `SERVE_DELAY` = 1, they rise in the cycle immediately after `sb_clear`.
- **Exit to scored pulse:** ball exit sampled at edge N in `PLAY` → scored pulse and `ball_en` = 0 during cycle N+1.
- **Win decision:** `CHECK` is cycle N+3, once the scoreboard has had a full cycle to update. `game_over` rises in cycle N+4.
- **Next serve:** when no one has won, `serve` fires `SERVE_DELAY` cycles after `CHECK`.
- **Serve timer:** width is `$clog2(SERVE_DELAY+1)`. It never wraps; it holds at 0 outside `SERVE_WAIT`.

## Configuration
- **`PONG_WIN_BY_TWO_EN` defined:** a win requires score ≥ `WIN_SCORE` and a lead of ≥ 2. The lead is computed in `SCORE_W+1` bits, so there is no underflow. Play continues past `WIN_SCORE` until the margin reaches 2.
- **`PONG_WIN_BY_TWO_EN` undefined:** the first score to reach `WIN_SCORE` wins.

## Structure
- **`pong_pkg`** holds:
  - `match_state_t`, the enum `IDLE, CLEAR, SERVE_WAIT, PLAY, SCORED, CHECK, OVER`.
  - Side constants `SIDE_P1` = 1'b0 and `SIDE_P2` = 1'b1, shared by `serve_dir` and `winner`.
- **`serve_timer`** is the single sub-module: a loadable down-counter with `load`, `en` and `zero` ports, parameterised by `SERVE_DELAY`.

## Test plan
- Reset low mid-`PLAY` → all outputs 0 and state `IDLE` asynchronously; no pulses after release until `start`.
- `start` one cycle, `SERVE_DELAY` = 4 → `sb_clear` in the next cycle; `serve` = 1 and `ball_en` = 1 exactly 4 cycles later.
- In `PLAY`, `ball_out_right` = 1 → one `p1_scored` pulse, `serve_dir` = 1, next `serve` after `CHECK` + 4 cycles. `ball_out_left` = 1 → one `p2_scored` pulse, `serve_dir` = 0.
- `ball_out_left` and `ball_out_right` both 1 together → `p1_scored` only; `p2_scored` stays 0.
- `WIN_SCORE` = 3, scores fed back by a bench scoreboard, three points to paddle 2 → `game_over` = 1 and `winner` = 1; `start` held 5 cycles → exactly one `sb_clear`.
- `PONG_WIN_BY_TWO_EN` defined, `WIN_SCORE` = 3, scores reach 3–2 → no `game_over`, serve continues; at 4–2 → `game_over` = 1 and `winner` = 0.

Source files
------------

// File: rtl/match_controller_pkg.sv
// Shared types for the pong match sequencer: FSM state encoding and side constants.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SERVE_WAIT,
        PLAY,
        SCORED,
        CHECK,
        OVER
    } match_state_t;

    // One encoding for both serve_dir and winner.
    localparam logic SIDE_P1 = 1'b0;
    localparam logic SIDE_P2 = 1'b1;

endpackage

// File: rtl/match_controller_if.sv
// Signal bundle between match_controller (master) and the ball/scoreboard logic (slave).
interface match_controller_if #(
    parameter int SCORE_W = 8
);
    // No valid/ready pairs here: every strobe is a single-cycle pulse that the
    // receiver must take in the cycle it is high, and no side can stall the other.
    logic               start;
    logic               ball_out_left;
    logic               ball_out_right;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic               sb_clear;
    logic               p1_scored;
    logic               p2_scored;
    logic               serve;
    logic               serve_dir;
    logic               ball_en;
    logic               game_over;
    logic               winner;

    modport master (
        input  start, ball_out_left, ball_out_right, p1_score, p2_score,
        output sb_clear, p1_scored, p2_scored, serve, serve_dir, ball_en,
               game_over, winner
    );

    modport slave (
        output start, ball_out_left, ball_out_right, p1_score, p2_score,
        input  sb_clear, p1_scored, p2_scored, serve, serve_dir, ball_en,
               game_over, winner
    );

endinterface

// File: rtl/match_controller_serve_timer.sv
// Loadable down-counter timing the gap before each serve; saturates at zero.
module serve_timer #(
    parameter  int SERVE_DELAY = 60,
    localparam int TW          = $clog2(SERVE_DELAY + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_en,
    output logic          o_zero,
    output logic [TW-1:0] o_count
);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= TW'(SERVE_DELAY - 1);
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - TW'(1);
        end
    end

    assign o_zero  = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/match_controller.sv
// Pong game-flow sequencer: clear, serve timing, score pulses and win check.
// Build option: define PONG_WIN_BY_TWO_EN to require a two-point lead to win.
module match_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    match_controller_if.master bus,
    output match_state_t       o_dbg_state
);

    localparam int                 TW        = $clog2(SERVE_DELAY + 1);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
    localparam bit                 SERVE_NOW = (SERVE_DELAY == 1);

    match_state_t r_state;
    match_state_t w_state_nxt;

    logic r_sb_clear, r_p1_scored, r_p2_scored, r_serve;
    logic r_serve_dir, r_ball_en, r_game_over, r_winner, r_scored_wait;
    logic w_sb_clear_nxt, w_p1_scored_nxt, w_p2_scored_nxt, w_serve_nxt;
    logic w_serve_dir_nxt, w_ball_en_nxt, w_game_over_nxt, w_winner_nxt;
    logic w_scored_wait_nxt;

    logic          w_timer_load;
    logic          w_timer_en;
    logic          w_timer_zero;
    logic [TW-1:0] w_timer_count;
    logic          w_p1_win;
    logic          w_p2_win;

    assign w_timer_en = (r_state == SERVE_WAIT);

    serve_timer #(
        .SERVE_DELAY (SERVE_DELAY)
    ) u_serve_timer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_timer_load),
        .i_en    (w_timer_en),
        .o_zero  (w_timer_zero),
        .o_count (w_timer_count)
    );

`ifdef PONG_WIN_BY_TWO_EN
    // Differences carry one extra bit; a set MSB means the leader is the other side.
    localparam logic [SCORE_W:0] LEAD2 = (SCORE_W + 1)'(2);
    logic [SCORE_W:0] w_diff_12;
    logic [SCORE_W:0] w_diff_21;
    assign w_diff_12 = {1'b0, bus.p1_score} - {1'b0, bus.p2_score};
    assign w_diff_21 = {1'b0, bus.p2_score} - {1'b0, bus.p1_score};
    assign w_p1_win  = (bus.p1_score >= WIN) && !w_diff_12[SCORE_W] && (w_diff_12 >= LEAD2);
    assign w_p2_win  = (bus.p2_score >= WIN) && !w_diff_21[SCORE_W] && (w_diff_21 >= LEAD2);
`else
    assign w_p1_win = (bus.p1_score >= WIN);
    assign w_p2_win = (bus.p2_score >= WIN);
`endif

    // Outputs are registered from next-cycle values, so serve is raised one edge
    // early: it is high during the SERVE_WAIT cycle in which the timer reads 0.
    always_comb begin
        w_state_nxt       = r_state;
        w_sb_clear_nxt    = 1'b0;
        w_p1_scored_nxt   = 1'b0;
        w_p2_scored_nxt   = 1'b0;
        w_serve_nxt       = 1'b0;
        w_ball_en_nxt     = 1'b0;
        w_game_over_nxt   = 1'b0;
        w_serve_dir_nxt   = r_serve_dir;
        w_winner_nxt      = r_winner;
        w_scored_wait_nxt = 1'b0;
        w_timer_load      = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt    = CLEAR;
                    w_sb_clear_nxt = 1'b1;
                end
            end
            CLEAR: begin
                w_timer_load    = 1'b1;
                w_serve_dir_nxt = SIDE_P1;
                w_state_nxt     = SERVE_WAIT;
                if (SERVE_NOW) begin
                    w_serve_nxt   = 1'b1;
                    w_ball_en_nxt = 1'b1;
                end
            end
            SERVE_WAIT: begin
                if (w_timer_zero) begin
                    w_state_nxt   = PLAY;
                    w_ball_en_nxt = 1'b1;
                end else if (w_timer_count == TW'(1)) begin
                    w_serve_nxt   = 1'b1;
                    w_ball_en_nxt = 1'b1;
                end
            end
            PLAY: begin
                w_ball_en_nxt = 1'b1;
                if (bus.ball_out_right) begin
                    w_p1_scored_nxt = 1'b1;
                    w_serve_dir_nxt = SIDE_P2;
                    w_ball_en_nxt   = 1'b0;
                    w_state_nxt     = SCORED;
                end else if (bus.ball_out_left) begin
                    w_p2_scored_nxt = 1'b1;
                    w_serve_dir_nxt = SIDE_P1;
                    w_ball_en_nxt   = 1'b0;
                    w_state_nxt     = SCORED;
                end
            end
            SCORED: begin
                // Two cycles here: the pulse cycle, then one for the scoreboard to settle.
                if (r_scored_wait) begin
                    w_state_nxt = CHECK;
                end else begin
                    w_scored_wait_nxt = 1'b1;
                end
            end
            CHECK: begin
                if (w_p1_win) begin
                    w_state_nxt     = OVER;
                    w_game_over_nxt = 1'b1;
                    w_winner_nxt    = SIDE_P1;
                end else if (w_p2_win) begin
                    w_state_nxt     = OVER;
                    w_game_over_nxt = 1'b1;
                    w_winner_nxt    = SIDE_P2;
                end else begin
                    w_timer_load = 1'b1;
                    w_state_nxt  = SERVE_WAIT;
                    if (SERVE_NOW) begin
                        w_serve_nxt   = 1'b1;
                        w_ball_en_nxt = 1'b1;
                    end
                end
            end
            OVER: begin
                w_game_over_nxt = 1'b1;
                if (bus.start) begin
                    w_state_nxt     = CLEAR;
                    w_sb_clear_nxt  = 1'b1;
                    w_game_over_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_sb_clear    <= 1'b0;
            r_p1_scored   <= 1'b0;
            r_p2_scored   <= 1'b0;
            r_serve       <= 1'b0;
            r_serve_dir   <= SIDE_P1;
            r_ball_en     <= 1'b0;
            r_game_over   <= 1'b0;
            r_winner      <= SIDE_P1;
            r_scored_wait <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sb_clear    <= w_sb_clear_nxt;
            r_p1_scored   <= w_p1_scored_nxt;
            r_p2_scored   <= w_p2_scored_nxt;
            r_serve       <= w_serve_nxt;
            r_serve_dir   <= w_serve_dir_nxt;
            r_ball_en     <= w_ball_en_nxt;
            r_game_over   <= w_game_over_nxt;
            r_winner      <= w_winner_nxt;
            r_scored_wait <= w_scored_wait_nxt;
        end
    end

    assign bus.sb_clear  = r_sb_clear;
    assign bus.p1_scored = r_p1_scored;
    assign bus.p2_scored = r_p2_scored;
    assign bus.serve     = r_serve;
    assign bus.serve_dir = r_serve_dir;
    assign bus.ball_en   = r_ball_en;
    assign bus.game_over = r_game_over;
    assign bus.winner    = r_winner;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller (WIN_SCORE=3, SERVE_DELAY=4 plus a SERVE_DELAY=1 instance).
// Honours PONG_WIN_BY_TWO_EN for the end-of-match scoring sequence.
module tb_match_controller;
    import pong_pkg::*;

    localparam int SCORE_W = 8;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [1:0]         exp_q[$];
    logic [SCORE_W-1:0] m_p1 = '0;
    logic [SCORE_W-1:0] m_p2 = '0;
    match_state_t       dbg_state;
    match_state_t       dbg_state1;

    match_controller_if #(.SCORE_W(SCORE_W)) u_if ();
    match_controller_if #(.SCORE_W(SCORE_W)) u_if1 ();

    match_controller #(
        .WIN_SCORE (3),
        .SERVE_DELAY (4),
        .SCORE_W (SCORE_W)
    ) u_dut (
        .clk (clk),
        .reset (reset),
        .bus (u_if.master),
        .o_dbg_state (dbg_state)
    );

    match_controller #(
        .WIN_SCORE (3),
        .SERVE_DELAY (1),
        .SCORE_W (SCORE_W)
    ) u_dut1 (
        .clk (clk),
        .reset (reset),
        .bus (u_if1.master),
        .o_dbg_state (dbg_state1)
    );

    assign u_if.p1_score        = m_p1;
    assign u_if.p2_score        = m_p2;
    assign u_if1.p1_score       = '0;
    assign u_if1.p2_score       = '0;
    assign u_if1.ball_out_left  = 1'b0;
    assign u_if1.ball_out_right = 1'b0;

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment model of the scoreboard the controller talks to
    always @(posedge clk) begin
        if (u_if.sb_clear) begin
            m_p1 <= '0;
            m_p2 <= '0;
        end else begin
            if (u_if.p1_scored) m_p1 <= m_p1 + 1'b1;
            if (u_if.p2_scored) m_p2 <= m_p2 + 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each observed score pulse is matched against the queued expectation
    always @(negedge clk) begin : p_mon
        logic [1:0] e;
        if (u_if.p1_scored || u_if.p2_scored) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_score_pulse", {30'd0, u_if.p2_scored, u_if.p1_scored}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("score_pulse", {30'd0, u_if.p2_scored, u_if.p1_scored}, {30'd0, e});
            end
        end
    end

    // Entered at the negedge of the serve cycle; plays one point and follows it to CHECK.
    task automatic play_point(input string tag, input bit right, input bit left,
                              input bit exp_p1, input bit exp_p2, input bit exp_dir,
                              input bit exp_over, input bit exp_winner);
        @(negedge clk);
        chk({tag, "_play_state"}, 32'(dbg_state), 32'(PLAY));
        chk({tag, "_play_ball_en"}, 32'(u_if.ball_en), 32'd1);
        u_if.ball_out_right = right;
        u_if.ball_out_left  = left;
        exp_q.push_back({exp_p2, exp_p1});
        @(negedge clk);
        u_if.ball_out_right = 1'b0;
        u_if.ball_out_left  = 1'b0;
        chk({tag, "_ball_en_off"}, 32'(u_if.ball_en), 32'd0);
        chk({tag, "_serve_dir"}, 32'(u_if.serve_dir), 32'(exp_dir));
        repeat (2) @(negedge clk);
        chk({tag, "_check_state"}, 32'(dbg_state), 32'(CHECK));
        if (exp_over) begin
            @(negedge clk);
            chk({tag, "_game_over"}, 32'(u_if.game_over), 32'd1);
            chk({tag, "_winner"}, 32'(u_if.winner), 32'(exp_winner));
        end else begin
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (k == 1) chk({tag, "_no_game_over"}, 32'(u_if.game_over), 32'd0);
                chk({tag, "_next_serve"}, 32'(u_if.serve), 32'(k == 4));
            end
        end
    endtask

    initial begin
        int sb_cnt;
        int act_cnt;

        reset               = 1'b0;
        u_if.start          = 1'b0;
        u_if.ball_out_left  = 1'b0;
        u_if.ball_out_right = 1'b0;
        u_if1.start         = 1'b0;

        @(negedge clk);
        chk("reset_outputs", {24'd0, u_if.sb_clear, u_if.p1_scored, u_if.p2_scored, u_if.serve,
            u_if.serve_dir, u_if.ball_en, u_if.game_over, u_if.winner}, 32'd0);
        chk("reset_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        chk("idle_no_clear", 32'(u_if.sb_clear), 32'd0);

        // Start pulse, then serve timing; ball exits during SERVE_WAIT must be ignored
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        chk("start_sb_clear", 32'(u_if.sb_clear), 32'd1);
        u_if.ball_out_left = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) chk("sb_clear_one_cycle", 32'(u_if.sb_clear), 32'd0);
            chk("first_serve_timing", 32'(u_if.serve), 32'(k == 4));
            if (k == 4) begin
                chk("first_serve_ball_en", 32'(u_if.ball_en), 32'd1);
                u_if.ball_out_left = 1'b0;
            end
        end

        play_point("p1_point", 1'b1, 1'b0, 1'b1, 1'b0, SIDE_P2, 1'b0, 1'b0); // 1-0
        play_point("p2_point", 1'b0, 1'b1, 1'b0, 1'b1, SIDE_P1, 1'b0, 1'b0); // 1-1
        play_point("both_out", 1'b1, 1'b1, 1'b1, 1'b0, SIDE_P2, 1'b0, 1'b0); // 2-1
        play_point("p2_tie",   1'b0, 1'b1, 1'b0, 1'b1, SIDE_P1, 1'b0, 1'b0); // 2-2
`ifdef PONG_WIN_BY_TWO_EN
        play_point("p1_3_2",   1'b1, 1'b0, 1'b1, 1'b0, SIDE_P2, 1'b0, 1'b0); // 3-2, lead 1
        play_point("p1_4_2",   1'b1, 1'b0, 1'b1, 1'b0, SIDE_P2, 1'b1, SIDE_P1);
`else
        play_point("p2_wins",  1'b0, 1'b1, 1'b0, 1'b1, SIDE_P1, 1'b1, SIDE_P2);
`endif

        // Restart with start held for five cycles: exactly one clear
        sb_cnt = 0;
        u_if.start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 5) u_if.start = 1'b0;
            if (u_if.sb_clear) sb_cnt++;
            if (k == 1) chk("restart_game_over_low", 32'(u_if.game_over), 32'd0);
            if (k == 5) chk("restart_serve", 32'(u_if.serve), 32'd1);
        end
        chk("restart_single_clear", 32'(sb_cnt), 32'd1);
        chk("mid_play_state", 32'(dbg_state), 32'(PLAY));

        // Asynchronous reset in the middle of PLAY
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", {24'd0, u_if.sb_clear, u_if.p1_scored, u_if.p2_scored, u_if.serve,
            u_if.serve_dir, u_if.ball_en, u_if.game_over, u_if.winner}, 32'd0);
        chk("async_reset_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        reset = 1'b1;
        act_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (u_if.sb_clear || u_if.serve || u_if.p1_scored || u_if.p2_scored ||
                u_if.ball_en || u_if.game_over) act_cnt++;
        end
        chk("post_reset_quiet", 32'(act_cnt), 32'd0);
        chk("post_reset_idle", 32'(dbg_state), 32'(IDLE));

        // SERVE_DELAY = 1: serve in the cycle right after the clear
        u_if1.start = 1'b1;
        @(negedge clk);
        u_if1.start = 1'b0;
        chk("d1_sb_clear", 32'(u_if1.sb_clear), 32'd1);
        chk("d1_no_early_serve", 32'(u_if1.serve), 32'd0);
        @(negedge clk);
        chk("d1_serve", 32'(u_if1.serve), 32'd1);
        chk("d1_ball_en", 32'(u_if1.ball_en), 32'd1);
        @(negedge clk);
        chk("d1_serve_pulse_end", 32'(u_if1.serve), 32'd0);
        chk("d1_play_state", 32'(dbg_state1), 32'(PLAY));

        repeat (2) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
